// File: rtl/frame_demux8x16_if.sv
// Bundle of the serial word input, the parallel frame output and the slot
// counter for frame_demux8x16. The "slave" modport is the deserializer's view.
// The "master" modport is the view of the environment that feeds and drains it.
interface frame_demux8x16_if #(
    parameter int WIDTH = 16
);
    // Serial word input side
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             flush;

    // Parallel frame output side: slots 0..7
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic             out_valid;
    logic             out_ready;

    // Status: next slot index, and FSM state (0 = FILL, 1 = FULL)
    logic [2:0]       count;
    logic             dbg_state;

    modport slave (
        input  in, in_valid, flush, out_ready,
        output in_ready, a, b, c, d, e, f, g, h, out_valid, count, dbg_state
    );

    modport master (
        output in, in_valid, flush, out_ready,
        input  in_ready, a, b, c, d, e, f, g, h, out_valid, count, dbg_state
    );
endinterface

// File: rtl/frame_demux8x16.sv
// frame_demux8x16: deserializes eight consecutive accepted words into the
// parallel slots a..h (slot order matches the Mux8Way16 select code). The
// completed frame is then offered downstream.
//
// Handshake rule, used on both sides: a transfer happens on a rising edge
// where valid and ready are both 1. Ready and valid are registered, and
// ready never depends on valid in the same cycle.
// - Input side: in_valid/in_ready. in_ready is high exactly in FILL.
// - Output side: out_valid/out_ready. out_valid is high exactly in FULL.
// flush (and reset above it) overrides both handshakes on the same edge.
module frame_demux8x16 #(
    parameter int WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    frame_demux8x16_if.slave    bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];
    logic             in_ready_q;
    logic             out_valid_q;

    // Next-state decode: flush beats both handshakes; a FULL frame is frozen
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        for (int i = 0; i < 8; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (bus.flush) begin
            count_d = 3'd0;
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.in_valid) begin
                        slot_d[count_q] = bus.in;
                        count_d         = count_q + 3'd1;
                        if (count_q == 3'd7) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State, counter, slots and the registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == FILL);
            out_valid_q <= (state_d == FULL);
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.dbg_state = state_q;
    assign bus.a         = slot_q[0];
    assign bus.b         = slot_q[1];
    assign bus.c         = slot_q[2];
    assign bus.d         = slot_q[3];
    assign bus.e         = slot_q[4];
    assign bus.f         = slot_q[5];
    assign bus.g         = slot_q[6];
    assign bus.h         = slot_q[7];

endmodule

// File: tb/tb_frame_demux8x16.sv
// Bench for frame_demux8x16: directed stimulus, an abstract frame model
// (the list of words accepted so far in the current frame), a per-cycle
// compare, and literal expectations from hand calculation.
module tb_frame_demux8x16;
    localparam int W = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    frame_demux8x16_if #(.WIDTH(W)) bus ();

    frame_demux8x16 #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // exp_q holds the words of the frame under construction; the frame is
    // complete when it holds eight. m_slot is what each output slot shows.
    logic [W-1:0] exp_q [$];
    logic [W-1:0] m_slot [8];
    bit           model_live = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            for (int k = 0; k < 8; k++) m_slot[k] = '0;
            model_live = 1'b1;
        end else if (bus.flush) begin
            exp_q.delete();
        end else if (exp_q.size() == 8) begin
            if (bus.out_ready) exp_q.delete();
        end else if (bus.in_valid) begin
            m_slot[exp_q.size()] = bus.in;
            exp_q.push_back(bus.in);
        end
    end

    function automatic logic [W-1:0] dut_slot(input int k);
        case (k)
            0: return bus.a;
            1: return bus.b;
            2: return bus.c;
            3: return bus.d;
            4: return bus.e;
            5: return bus.f;
            6: return bus.g;
            default: return bus.h;
        endcase
    endfunction

    // Counts cycles with out_valid high; directed tests clear it.
    int ov_cnt = 0;

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (model_live) begin
            chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() != 8));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() == 8));
            chk("dbg_state", 32'(bus.dbg_state), 32'(exp_q.size() == 8));
            chk("count",     32'(bus.count),     32'(exp_q.size() % 8));
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("slot%0d", k), 32'(dut_slot(k)), 32'(m_slot[k]));
            end
            if (bus.out_valid) ov_cnt++;
        end
    end

    // ---------------- driver ----------------
    // Apply one cycle of inputs; returns 2 time units after the edge.
    task automatic cyc(input logic v, input logic [W-1:0] din, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in        = din;
        bus.out_ready = r;
        bus.flush     = f;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},     32'(bus.count),     32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_a"},         32'(bus.a),         32'd0);
        chk({tag, "_h"},         32'(bus.h),         32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset state
        do_reset();
        chk_reset_vals("rst0");

        // 1: eight words back to back, consumer ready
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h1111 * (i + 1)), 1'b1, 1'b0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_a",         32'(bus.a),         32'h1111);
        chk("t1_d",         32'(bus.d),         32'h4444);
        chk("t1_h",         32'(bus.h),         32'h8888);
        chk("t1_count",     32'(bus.count),     32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t1_ov_cycles", 32'(ov_cnt),        32'd1);
        chk("t1_in_ready",  32'(bus.in_ready),  32'd1);

        // 2: consumer stalls 5 cycles while a 9th word 0xDEAD is offered
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
            chk("t2_in_ready_stall", 32'(bus.in_ready), 32'd0);
        end
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b0);
        chk("t2_ov_cycles", 32'(ov_cnt), 32'd6);
        chk("t2_a_kept",    32'(bus.a),  32'h1111);
        chk("t2_count",     32'(bus.count), 32'd0);

        // 3: in_valid toggling every other cycle
        ov_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'(i % 2 == 0), 16'(16'h0300 + i / 2), 1'b0, 1'b0);
            if (i == 5) chk("t3_count_mid", 32'(bus.count), 32'd3);
        end
        chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_h",         32'(bus.h),         32'h0307);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // 4: three words, then flush together with a 0xFFFF word
        cyc(1'b1, 16'h00A0, 1'b0, 1'b0);
        cyc(1'b1, 16'h00A1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00A2, 1'b0, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
        chk("t4_count", 32'(bus.count), 32'd0);
        chk("t4_a",     32'(bus.a),     32'h00A0);
        chk("t4_d",     32'(bus.d),     32'h0303);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h00B0 + i), 1'b0, 1'b0);
        chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_a_new",     32'(bus.a),         32'h00B0);
        chk("t4_h_new",     32'(bus.h),         32'h00B7);
        // flush on the same edge as a frame transfer
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("t4_flush_xfer_in_ready", 32'(bus.in_ready), 32'd1);

        // 5: reset after 5 accepts, and reset while FULL
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0);
        chk("t5_count5", 32'(bus.count), 32'd5);
        do_reset();
        chk_reset_vals("rst_mid");
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0D00 + i), 1'b0, 1'b0);
        chk("t5_full", 32'(bus.out_valid), 32'd1);
        do_reset();
        chk_reset_vals("rst_full");

        // 6: back-to-back frames; word index i - i/9 repeats the rejected word
        ov_cnt = 0;
        for (int i = 0; i < 27; i++) begin
            cyc(1'b1, 16'(16'h5000 + i - i / 9), 1'b1, 1'b0);
            if (i == 7) chk("t6_f1_valid", 32'(bus.out_valid), 32'd1);
            if (i == 8) chk("t6_f1_gap",   32'(bus.out_valid), 32'd0);
            if (i == 16) begin
                chk("t6_f2_valid", 32'(bus.out_valid), 32'd1);
                chk("t6_f2_a",     32'(bus.a),         32'h5008);
                chk("t6_f2_h",     32'(bus.h),         32'h500F);
            end
        end
        chk("t6_frames", 32'(ov_cnt), 32'd3);

        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
